dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
Multi-cycle data-memory access controller in the MEM stage. It sits directly upstream of the load formatter. It accepts load/store requests from the pipeline and stalls the pipeline for a fixed RAM latency. It performs store byte-lane alignment and merging into an internal word RAM, and presents the raw 32-bit read word plus the latched address and access type to the downstream load formatter, which does byte/half selection and sign extension.

Parameters:
WIDTH, 32, data and address width (only 32 supported)
ADDR_WIDTH, 12, byte-address bits used; RAM depth = 2^(ADDR_WIDTH-2) words
LATENCY, 2, cycles from request acceptance to done_o; legal range 1..15

Ports:
clk_i  in  1  clock; all state updates on its rising edge
rst_i  in  1  synchronous active-high reset
req_i  in  1  MEM-stage instruction is a load or store
we_i  in  1  1 = store, 0 = load; sampled with req_i
memtype_i  in  2  01 = byte, 10 = half, other values = word
memsign_i  in  1  load signedness; passed through to the formatter
a_i  in  WIDTH  byte address
wd_i  in  WIDTH  store data, right-justified
stall_o  out  1  freeze pipeline stages up to and including MEM
done_o  out  1  one-cycle pulse when the access completes
misalign_o  out  1  one-cycle pulse with done_o; access was misaligned and was dropped
rd_o  out  WIDTH  raw RAM word (feeds the formatter's rd_i)
a_o  out  WIDTH  latched request address (feeds the formatter's a_i)
memtype_o  out  2  latched memtype (feeds the formatter's memtype_i)
memsign_o  out  1  latched memsign (feeds the formatter's memsign_i)

Behaviour:
- Reset values:
  - state = IDLE, latency counter = 0.
  - done_o, misalign_o = 0.
  - rd_o, a_o = 0; memtype_o = 00; memsign_o = 0.
  - RAM contents are not reset.
- State machine has three states: IDLE, BUSY, DONE.
- IDLE:
  - If req_i = 1, capture we_i, memtype_i, memsign_i, a_i and wd_i into the request registers.
  - a_o, memtype_o and memsign_o update at this same edge.
  - Aligned request: go to BUSY with counter = LATENCY-1. If LATENCY = 1, go directly to DONE.
  - Misaligned request: go directly to DONE with the misaligned flag set.
- Misaligned definition:
  - half with a[0] = 1, or
  - word with a[1:0] != 00, or
  - byte: never misaligned.
- BUSY:
  - Decrement the counter each cycle.
  - When the counter equals 1, go to DONE at the next edge.
  - Net effect: a request accepted at edge E completes with done_o high in the cycle after edge E+LATENCY-1, i.e. LATENCY cycles after the request cycle.
- DONE:
  - Lasts exactly one cycle.
  - done_o = 1; misalign_o = the misaligned flag.
  - Next state is IDLE unconditionally. req_i is ignored in DONE; the next instruction is accepted in IDLE.
- stall_o (combinational): (state == IDLE && req_i) || state == BUSY. It is 0 in DONE, so the pipeline advances at the end of DONE.
- Load:
  - On the edge entering DONE, rd_o <= RAM[a[ADDR_WIDTH-1:2]] (full word, unshifted).
  - rd_o holds until the next completed load.
- Store:
  - Byte enables are decoded from the latched memtype and a[1:0]:
    - byte: lane a[1:0];
    - half: lanes {1,0} if a[1] = 0, else lanes {3,2};
    - word: all four lanes.
  - Write data is lane-replicated:
    - byte: {4{wd[7:0]}};
    - half: {2{wd[15:0]}};
    - word: wd.
  - Only enabled lanes are written, on the edge entering DONE. Stores leave rd_o unchanged.
- Misaligned access: no RAM write, rd_o unchanged, misalign_o = 1 during DONE.
- Addressing: only a[ADDR_WIDTH-1:2] indexes the RAM. Upper address bits are ignored, so addresses wrap modulo 2^ADDR_WIDTH.
- Reset mid-access: rst_i in BUSY aborts the access. There is no write and no done_o; the block returns to IDLE and all outputs take their reset values.
- Back-to-back accesses: the minimum request-to-request spacing is LATENCY+1 cycles (the DONE cycle plus the IDLE accept cycle).

Test Plan:
1. Reset, then word store a=0x10, wd=0xDEADBEEF, LATENCY=2 -> stall_o high in the request cycle and for 1 more cycle; done_o pulses 2 cycles after the request; a following word load at 0x10 returns rd_o=0xDEADBEEF.
2. Byte store a=0x13, wd=0x000000AA onto word 0x11223344 -> reload of 0x10 gives rd_o=0xAA223344; a_o=0x13 and memtype_o=01 are presented during the load's DONE.
3. Half store a=0x22, wd=0x0000CAFE onto word 0 -> reload of 0x20 gives 0xCAFE0000; a half store at 0x21 -> misalign_o=1 with done_o 1 cycle after the request, and the word is unchanged.
4. Word load a=0x6 (misaligned) -> done_o and misalign_o high in the next cycle, rd_o keeps its previous value, stall_o low in the DONE cycle.
5. rst_i asserted during BUSY of a word store 0xFFFFFFFF to 0x30 -> no done_o; a later load of 0x30 returns the prior contents; all outputs are 0 after reset.
6. With LATENCY=1 and ADDR_WIDTH=12, a store to 0x1004 followed by a load of 0x0004 -> aliased data is returned; done_o arrives 1 cycle after each request; requests are spaced 2 cycles apart.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller for the MEM stage.
// Holds the pipeline for a fixed RAM latency. Stores are written into an internal
// word RAM using byte enables. Loads return the raw 32-bit word, together with the
// latched address and access type, for the downstream load formatter.
module dmem_access_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LATENCY    = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [1:0]       memtype_i,
    input  logic             memsign_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] wd_i,
    output logic             stall_o,
    output logic             done_o,
    output logic             misalign_o,
    output logic [WIDTH-1:0] rd_o,
    output logic [WIDTH-1:0] a_o,
    output logic [1:0]       memtype_o,
    output logic             memsign_o
);

    localparam int unsigned Depth = 2 ** (ADDR_WIDTH - 2);
    localparam int unsigned IdxW  = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q;
    logic [3:0]       cnt_q;
    logic             we_q;
    logic [WIDTH-1:0] wd_q;
    logic [WIDTH-1:0] mem [Depth];

    logic                  accept;
    logic [ADDR_WIDTH-1:0] cur_a;
    logic [1:0]            cur_type;
    logic                  cur_we;
    logic [WIDTH-1:0]      cur_wd;
    logic                  cur_mis;
    logic                  enter_done;
    logic                  access;
    logic                  ram_we;
    logic [IdxW-1:0]       ram_idx;
    logic [3:0]            be;
    logic [WIDTH-1:0]      wdata;

    // With LATENCY=1 the access happens at the accept edge, so the live request is used
    // there. Otherwise the latched copy (a_o/memtype_o double as request registers) is used.
    always_comb begin
        accept   = (state_q == StIdle) && req_i;
        cur_a    = accept ? a_i[ADDR_WIDTH-1:0] : a_o[ADDR_WIDTH-1:0];
        cur_type = accept ? memtype_i : memtype_o;
        cur_we   = accept ? we_i : we_q;
        cur_wd   = accept ? wd_i : wd_q;

        case (cur_type)
            2'b01:   cur_mis = 1'b0;
            2'b10:   cur_mis = cur_a[0];
            default: cur_mis = (cur_a[1:0] != 2'b00);
        endcase

        enter_done = (accept && (cur_mis || (LATENCY == 1)))
                   || ((state_q == StBusy) && (cnt_q == 4'd1));
        access     = enter_done && !cur_mis && !rst_i;
        ram_we     = access && cur_we;
        ram_idx    = cur_a[ADDR_WIDTH-1:2];

        case (cur_type)
            2'b01: begin
                be    = 4'b0001 << cur_a[1:0];
                wdata = {4{cur_wd[7:0]}};
            end
            2'b10: begin
                be    = cur_a[1] ? 4'b1100 : 4'b0011;
                wdata = {2{cur_wd[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = cur_wd;
            end
        endcase
    end

    // Combinational stall: hold the pipeline while accepting a request and while busy.
    assign stall_o = accept || (state_q == StBusy);

    // Byte-lane RAM write on the edge entering DONE; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[ram_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Controller FSM with registered outputs and the load read-out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            wd_q       <= '0;
            done_o     <= 1'b0;
            misalign_o <= 1'b0;
            rd_o       <= '0;
            a_o        <= '0;
            memtype_o  <= 2'b00;
            memsign_o  <= 1'b0;
        end else begin
            done_o     <= 1'b0;
            misalign_o <= 1'b0;
            if (access && !cur_we) begin
                rd_o <= mem[ram_idx];
            end
            case (state_q)
                StIdle: begin
                    if (req_i) begin
                        we_q      <= we_i;
                        wd_q      <= wd_i;
                        a_o       <= a_i;
                        memtype_o <= memtype_i;
                        memsign_o <= memsign_i;
                        if (cur_mis) begin
                            // Misaligned: dropped, reported in a one-cycle DONE.
                            state_q    <= StDone;
                            done_o     <= 1'b1;
                            misalign_o <= 1'b1;
                        end else if (LATENCY == 1) begin
                            state_q <= StDone;
                            done_o  <= 1'b1;
                        end else begin
                            state_q <= StBusy;
                            cnt_q   <= 4'(LATENCY - 1);
                        end
                    end
                end
                StBusy: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= StDone;
                        done_o  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: a LATENCY=2 instance and a LATENCY=1 instance.
// A transaction-level model predicts every output on every cycle.
module tb_dmem_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        req [2];
    logic        we_s [2];
    logic        ms_s [2];
    logic [1:0]  mt_s [2];
    logic [31:0] a_s [2];
    logic [31:0] wd_s [2];
    logic        stall [2];
    logic        done [2];
    logic        mis [2];
    logic        mso [2];
    logic [1:0]  mto [2];
    logic [31:0] rd [2];
    logic [31:0] ao [2];

    dmem_access_ctrl #(.WIDTH(32), .ADDR_WIDTH(12), .LATENCY(2)) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .we_i(we_s[0]), .memtype_i(mt_s[0]),
        .memsign_i(ms_s[0]), .a_i(a_s[0]), .wd_i(wd_s[0]), .stall_o(stall[0]),
        .done_o(done[0]), .misalign_o(mis[0]), .rd_o(rd[0]), .a_o(ao[0]),
        .memtype_o(mto[0]), .memsign_o(mso[0])
    );

    dmem_access_ctrl #(.WIDTH(32), .ADDR_WIDTH(12), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .we_i(we_s[1]), .memtype_i(mt_s[1]),
        .memsign_i(ms_s[1]), .a_i(a_s[1]), .wd_i(wd_s[1]), .stall_o(stall[1]),
        .done_o(done[1]), .misalign_o(mis[1]), .rd_o(rd[1]), .a_o(ao[1]),
        .memtype_o(mto[1]), .memsign_o(mso[1])
    );

    // Expected outputs for the current cycle, set just after each rising edge.
    logic        exp_stall [2];
    logic        exp_done [2];
    logic        exp_mis [2];
    logic        exp_ms [2];
    logic [1:0]  exp_mt [2];
    logic [31:0] exp_rd [2];
    logic [31:0] exp_a [2];
    bit          exp_rd_known [2];
    bit          chk_en [2];
    logic        obs_mis [2];
    logic        obs_done [2];

    // Word memory model with per-byte "written" flags (the DUT RAM is not reset).
    logic [31:0] mdl_mem [2][1024];
    logic [3:0]  mdl_kb [2][1024];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic bit is_mis(input logic [1:0] mt, input logic [31:0] a);
        if (mt == 2'b01) return 1'b0;
        if (mt == 2'b10) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (chk_en[d]) begin
                check($sformatf("stall%0d", d), 32'(stall[d]), 32'(exp_stall[d]));
                check($sformatf("done%0d", d), 32'(done[d]), 32'(exp_done[d]));
                check($sformatf("misalign%0d", d), 32'(mis[d]), 32'(exp_mis[d]));
                check($sformatf("a_o%0d", d), ao[d], exp_a[d]);
                check($sformatf("memtype_o%0d", d), 32'(mto[d]), 32'(exp_mt[d]));
                check($sformatf("memsign_o%0d", d), 32'(mso[d]), 32'(exp_ms[d]));
                if (exp_rd_known[d]) check($sformatf("rd_o%0d", d), rd[d], exp_rd[d]);
            end
        end
    end

    task automatic scramble(input int d);
        we_s[d] = 1'($urandom);
        mt_s[d] = 2'($urandom);
        ms_s[d] = 1'($urandom);
        a_s[d]  = $urandom;
        wd_s[d] = $urandom;
    endtask

    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            req[d] = 1'b0;
            exp_stall[d] = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    // Called just after a rising edge while the DUT is idle. Returns one cycle after DONE.
    task automatic do_access(input int d, input bit we, input logic [1:0] mt, input bit ms,
                             input logic [31:0] a, input logic [31:0] wd, input bit junk);
        int lat = (d == 0) ? 2 : 1;
        bit m = is_mis(mt, a);
        int n = m ? 1 : lat;
        int idx = int'(a[11:2]);
        logic [31:0] w;
        logic [3:0] kb;
        req[d] = 1'b1; we_s[d] = we; mt_s[d] = mt; ms_s[d] = ms; a_s[d] = a; wd_s[d] = wd;
        exp_stall[d] = 1'b1; exp_done[d] = 1'b0; exp_mis[d] = 1'b0;
        @(posedge clk); #1;
        req[d] = 1'b0;
        scramble(d);
        exp_a[d] = a; exp_mt[d] = mt; exp_ms[d] = ms;
        for (int k = 1; k < n; k++) begin
            exp_stall[d] = 1'b1;
            @(posedge clk); #1;
        end
        exp_stall[d] = 1'b0; exp_done[d] = 1'b1; exp_mis[d] = m;
        if (!m) begin
            if (we) begin
                w = mdl_mem[d][idx];
                kb = mdl_kb[d][idx];
                case (mt)
                    2'b01: begin
                        w[8*int'(a[1:0]) +: 8] = wd[7:0];
                        kb[a[1:0]] = 1'b1;
                    end
                    2'b10: begin
                        w[16*int'(a[1]) +: 16] = wd[15:0];
                        kb[2*int'(a[1])] = 1'b1;
                        kb[2*int'(a[1])+1] = 1'b1;
                    end
                    default: begin
                        w = wd;
                        kb = 4'hF;
                    end
                endcase
                mdl_mem[d][idx] = w;
                mdl_kb[d][idx] = kb;
            end else begin
                exp_rd[d] = mdl_mem[d][idx];
                exp_rd_known[d] = (mdl_kb[d][idx] == 4'hF);
            end
        end
        // A request raised during DONE must be ignored.
        if (junk) begin
            scramble(d);
            req[d] = 1'b1;
        end
        obs_mis[d] = mis[d];
        obs_done[d] = done[d];
        @(posedge clk); #1;
        req[d] = 1'b0;
        exp_done[d] = 1'b0; exp_mis[d] = 1'b0; exp_stall[d] = 1'b0;
    endtask

    // Word store on instance 0, aborted by reset in its BUSY cycle.
    task automatic rst_busy(input logic [31:0] a, input logic [31:0] wd);
        req[0] = 1'b1; we_s[0] = 1'b1; mt_s[0] = 2'b00; ms_s[0] = 1'b0;
        a_s[0] = a; wd_s[0] = wd;
        exp_stall[0] = 1'b1;
        @(posedge clk); #1;
        req[0] = 1'b0;
        exp_a[0] = a; exp_mt[0] = 2'b00; exp_ms[0] = 1'b0; exp_stall[0] = 1'b1;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        exp_a[0] = 32'h0; exp_mt[0] = 2'b00; exp_ms[0] = 1'b0;
        exp_rd[0] = 32'h0; exp_rd_known[0] = 1'b1;
        exp_stall[0] = 1'b0; exp_done[0] = 1'b0; exp_mis[0] = 1'b0;
        check("t5_rst_a", ao[0], 32'h0);
        check("t5_rst_rd", rd[0], 32'h0);
        check("t5_rst_done", 32'(done[0]), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; we_s[d] = 1'b0; ms_s[d] = 1'b0; mt_s[d] = 2'b00;
            a_s[d] = 32'h0; wd_s[d] = 32'h0; chk_en[d] = 1'b0;
            for (int i = 0; i < 1024; i++) begin
                mdl_mem[d][i] = 32'h0;
                mdl_kb[d][i] = 4'h0;
            end
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            exp_stall[d] = 1'b0; exp_done[d] = 1'b0; exp_mis[d] = 1'b0; exp_ms[d] = 1'b0;
            exp_mt[d] = 2'b00; exp_a[d] = 32'h0; exp_rd[d] = 32'h0; exp_rd_known[d] = 1'b1;
            chk_en[d] = 1'b1;
        end
        @(posedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        idle(0, 1);

        // 1: word store then load.
        do_access(0, 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        check("t1_store_done", 32'(obs_done[0]), 32'h1);
        do_access(0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0);
        check("t1_rd", rd[0], 32'hDEADBEEF);

        // 2: byte store merges into one lane.
        do_access(0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h11223344, 1'b0);
        do_access(0, 1'b1, 2'b01, 1'b0, 32'h13, 32'h000000AA, 1'b1);
        do_access(0, 1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 1'b0);
        check("t2_rd", rd[0], 32'hAA223344);
        check("t2_a_o", ao[0], 32'h13);
        check("t2_memtype_o", 32'(mto[0]), 32'h1);

        // 3: half store to the upper lanes, then a misaligned half store.
        do_access(0, 1'b1, 2'b00, 1'b0, 32'h20, 32'h0, 1'b0);
        do_access(0, 1'b1, 2'b10, 1'b0, 32'h22, 32'h0000CAFE, 1'b0);
        do_access(0, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1'b0);
        check("t3_rd", rd[0], 32'hCAFE0000);
        do_access(0, 1'b1, 2'b10, 1'b0, 32'h21, 32'h00001234, 1'b0);
        check("t3_misalign", 32'(obs_mis[0]), 32'h1);
        do_access(0, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1'b0);
        check("t3_rd_unchanged", rd[0], 32'hCAFE0000);

        // 4: misaligned word load leaves rd_o alone.
        do_access(0, 1'b0, 2'b11, 1'b0, 32'h6, 32'h0, 1'b0);
        check("t4_misalign", 32'(obs_mis[0]), 32'h1);
        check("t4_rd_kept", rd[0], 32'hCAFE0000);

        // 5: reset during BUSY aborts a store.
        do_access(0, 1'b1, 2'b00, 1'b0, 32'h30, 32'h12345678, 1'b0);
        rst_busy(32'h30, 32'hFFFFFFFF);
        idle(0, 1);
        do_access(0, 1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 1'b0);
        check("t5_rd_prior", rd[0], 32'h12345678);

        // 6: LATENCY=1, address aliasing, back-to-back at minimum spacing.
        do_access(1, 1'b1, 2'b00, 1'b0, 32'h1004, 32'h5A5A1234, 1'b0);
        check("t6_store_done", 32'(obs_done[1]), 32'h1);
        do_access(1, 1'b0, 2'b00, 1'b0, 32'h0004, 32'h0, 1'b0);
        check("t6_rd_alias", rd[1], 32'h5A5A1234);

        // Random traffic on a small window of words with random upper bits.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 150; i++) begin
                idle(d, int'($urandom_range(0, 2)));
                ra = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 15)) << 2);
                if ($urandom_range(0, 1) == 1) ra[1:0] = 2'($urandom);
                do_access(d, 1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom,
                          1'($urandom));
            end
        end
        idle(0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
